arb_requester: RTL
==================

# arb_requester

Requester-side agent for the 4-way priority arbiter: one instance per client, mapped to one bit of the arbiter's `req`/`grant` vectors. It accepts a burst command from its local client and raises its request line. It holds the request until its own grant bit is seen, then issues the burst beat by beat, pausing whenever it is pre-empted. When the burst completes it releases the request and reports completion. Four instances (`CLIENT_ID` 0..3) plus the arbiter form the complete shared-resource access path; bit 3 is the highest-priority client (X0).

## Interface
- `CLIENT_ID`, 0: index of this client's bit in `req`/`grant` (0..3).
- `LEN_W`, 4: width of burst length field.
- `TIMEOUT_CYC`, 64: request-wait limit in cycles. Used only with `ARB_REQ_TIMEOUT_EN`; legal range 1..2^16-1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command strobe from the local client.
- `len`  in  LEN_W  burst length minus one, sampled with `start`; 0 means 1 beat.
- `grant`  in  4  grant vector from the arbiter; only `grant[CLIENT_ID]` is used.
- `req`  out  1  request to the arbiter; drives `req[CLIENT_ID]`.
- `busy`  out  1  high in any state except IDLE.
- `xfer_en`  out  1  beat strobe; the client moves one data beat in this cycle.
- `beat_idx`  out  LEN_W  index of the current beat, 0..len.
- `done`  out  1  one-cycle pulse after the last beat.
- `timeout_err`  out  1  one-cycle pulse when the request is abandoned.

## Operation
- FSM states: IDLE, REQ, XFER, REL. Reset forces IDLE.
- Reset values: `req`=0, `busy`=0, `xfer_en`=0, `beat_idx`=0, `done`=0, `timeout_err`=0, wait counter=0.
- IDLE:
  - `start`=1 latches `len` into `len_q`, clears `beat_idx` and the wait counter, then goes to REQ.
  - `grant[CLIENT_ID]` is ignored in IDLE.
- REQ:
  - `req`=1.
  - An edge with `grant[CLIENT_ID]`=1 moves to XFER.
  - Otherwise the wait counter increments and saturates.
- XFER:
  - `req`=1.
  - `xfer_en` = (state==XFER) & `grant[CLIENT_ID]`. This is combinational from `grant`, so pre-emption stops beats in the same cycle.
  - On each edge with `xfer_en`=1: if `beat_idx`==`len_q`, go to REL; else increment `beat_idx`.
  - Grant lost mid-burst: stay in XFER, keep `req`=1, hold `beat_idx`, and resume the same beat when the grant returns. No beat is skipped or repeated.
- REL:
  - `req`=0 and `done`=1 for exactly one cycle, then IDLE.
  - `beat_idx` holds its final value until the next `start`.
- `start` while `busy`=1 is ignored and the command is dropped (client must check `busy`).
- `start` in the same cycle as `reset`: reset wins.
- Reset mid-burst: returns to IDLE next edge with all outputs at reset values; no `done` pulse.
- Other bits of `grant` never affect this block.

## Timing
- `start` at edge t gives `req`=1 from cycle t+1.
- With a registered-grant arbiter and no competition, `grant[CLIENT_ID]`=1 from t+2. XFER is entered at edge t+2 and the first `xfer_en` occurs in cycle t+3.
- Uncontested burst of `len`+1 beats: `xfer_en` high for `len`+1 consecutive cycles. `done` is high in the cycle after the last beat; `req` falls in that same cycle.
- Minimum command-to-command spacing: `busy` drops the cycle after `done`, so the next `start` can be accepted at that edge.

## Configuration
- `ARB_REQ_TIMEOUT_EN` defined:
  - In REQ, when the wait counter reaches `TIMEOUT_CYC` with no grant, the FSM returns to IDLE.
  - `req` drops, `timeout_err`=1 for one cycle, and no `done` pulse is produced.
  - The wait counter runs only in REQ; it does not count grant loss during XFER.
- `ARB_REQ_TIMEOUT_EN` undefined:
  - The block waits in REQ indefinitely.
  - `timeout_err` is tied to 0 and the wait counter is not built.

## Test plan
- Single client, ID 0: `start` with `len`=3 and no competition. Expect `req` rising at t+1, exactly 4 `xfer_en` cycles with `beat_idx` 0,1,2,3, then `done`=1 for 1 cycle and `req`=0.
- Priority: IDs 0 and 3 start in the same cycle, both with `len`=1. ID 3 completes 2 beats first, then ID 0 is granted and completes; both `done` pulses occur, ID 3's first.
- Pre-emption: ID 1 is mid-burst at `beat_idx`=2 of `len`=5 when ID 2 starts. ID 1's `xfer_en` drops with `beat_idx` held at 2, then resumes at 2 after ID 2's `done`; total of 6 beats, none duplicated.
- Command during busy: a second `start` with `len`=7 arrives during XFER. It is ignored and the burst finishes with the original length.
- Reset at `beat_idx`=1: next cycle `req`=0, `busy`=0, `beat_idx`=0, and no `done` pulse.
- With `ARB_REQ_TIMEOUT_EN` and `TIMEOUT_CYC`=8: ID 0 is starved by a long ID 3 burst. Expect `timeout_err` pulse 8 cycles after REQ entry, `req`=0, and no `done` pulse.

Source files
------------

// File: rtl/arb_requester.sv
// Requester-side agent for the 4-way priority arbiter: requests, issues a burst beat by beat, releases.
// Optional request-wait timeout is built when ARB_REQ_TIMEOUT_EN is defined.
module arb_requester #(
    parameter int unsigned CLIENT_ID   = 0,
    parameter int unsigned LEN_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [3:0]       grant,
    output logic             req,
    output logic             busy,
    output logic             xfer_en,
    output logic [LEN_W-1:0] beat_idx,
    output logic             done,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_REL  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic [LEN_W-1:0] beat_d;
    logic             my_grant;
    logic             timeout_hit_c;
    logic             unused_grant;

    assign my_grant     = grant[2'(CLIENT_ID)];
    assign unused_grant = ^grant;

    // Combinational so that pre-emption stops beats in the same cycle the grant drops.
    assign xfer_en = (state_q == S_XFER) && my_grant;

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = 16;

    logic [WAIT_W-1:0] wait_q;

    // Counts ungranted cycles in REQ only; grant loss during XFER is not a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            wait_q <= '0;
        end else if ((state_q == S_REQ) && !my_grant && (wait_q != '1)) begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end

    assign timeout_hit_c = (state_q == S_REQ) && !my_grant &&
                           (wait_q == WAIT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_cfg;

    assign unused_cfg    = (TIMEOUT_CYC == 0);
    assign timeout_hit_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, burst length capture and beat advance.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_idx;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    len_d   = len;
                    beat_d  = '0;
                end
            end
            S_REQ: begin
                if (my_grant) begin
                    state_d = S_XFER;
                end else if (timeout_hit_c) begin
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                if (xfer_en) begin
                    if (beat_idx == len_q) begin
                        state_d = S_REL;
                    end else begin
                        beat_d = beat_idx + LEN_W'(1);
                    end
                end
            end
            S_REL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q       <= '0;
            beat_idx    <= '0;
            req         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            len_q       <= len_d;
            beat_idx    <= beat_d;
            req         <= (state_d == S_REQ) || (state_d == S_XFER);
            busy        <= (state_d != S_IDLE);
            done        <= (state_d == S_REL);
            timeout_err <= timeout_hit_c;
        end
    end

endmodule
